data_mem_arbiter: RTL
=====================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: width of address, write-data and read-data buses.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning), clock and reset first:
  clk_i  input  1  single clock; all state updates on the rising edge.
  rst_ni  input  1  reset, asynchronous and active-low.
  req_valid_i  input  2  per-requester request valid; bit k belongs to requester k.
  req_ready_o  output  2  per-requester accept; at most one bit high.
  req_we_i  input  2  per-requester write enable (1 = store).
  req_type_i  input  2x2  per-requester access size: 00 byte, 01 half, 10 word.
  req_sign_i  input  2  per-requester sign-extend for loads.
  req_addr_i  input  2xADDR_WIDTH  per-requester byte address.
  req_wdata_i  input  2xADDR_WIDTH  per-requester store data.
  rsp_valid_o  output  2  one-cycle response pulse per requester.
  rsp_err_o  output  1  misaligned-access flag, qualified by rsp_valid_o.
  rsp_rdata_o  output  ADDR_WIDTH  load data, qualified by rsp_valid_o.
  mem_write_en_o  output  1  write enable to the data-memory top.
  mem_type_o  output  2  access size to the data-memory top.
  mem_sign_o  output  1  sign control to the data-memory top.
  mem_addr_o  output  ADDR_WIDTH  byte address to the data-memory top.
  mem_write_data_o  output  ADDR_WIDTH  store data to the data-memory top.
  mem_read_data_i  input  ADDR_WIDTH  combinational read data from the data-memory top.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-004 In IDLE, req_ready_o SHALL be high, combinationally, only for the arbitration winner among the valid requesters; in ACCESS and RESP it SHALL be 2'b00.
REQ-005 A handshake SHALL occur when req_valid_i[k] and req_ready_o[k] are both high. On a handshake the block SHALL latch we, type, sign, addr, wdata and the grant index k, then enter ACCESS.
REQ-006 ACCESS SHALL last exactly one cycle. During it, the mem_* outputs SHALL be driven from the latched request, the block SHALL capture mem_read_data_i into a register, and the FSM SHALL then enter RESP.
REQ-007 RESP SHALL last exactly one cycle with rsp_valid_o[k] = 1 for the granted requester. For stores, rsp_rdata_o SHALL be 0. The FSM SHALL then return to IDLE.
REQ-008 Latency and throughput: with a handshake in cycle N, the memory access SHALL occur in N+1 (write commits at the end of N+1), the response SHALL appear in N+2, and the next handshake SHALL be no earlier than N+3.
REQ-009 Misalignment is defined as a halfword with addr[0]=1 or a word with addr[1:0]!=00. A misaligned request SHALL still pass through ACCESS but with mem_write_en_o=0, and SHALL respond with rsp_err_o=1 and rsp_rdata_o=0.
REQ-010 Outside ACCESS, all mem_* outputs SHALL be 0. Outside RESP, rsp_valid_o, rsp_err_o and rsp_rdata_o SHALL be 0.
REQ-011 If both requesters are valid in the same IDLE cycle, exactly one SHALL be granted; the loser SHALL stay pending (valid held) and be considered again at the next IDLE.
REQ-012 Request fields SHALL be sampled only at handshake; changes to req_* after handshake SHALL have no effect on the transaction in flight.
REQ-013 A requester whose type is 11 SHALL be treated as a word access.

Reset
REQ-014 Asserting rst_ni low SHALL, asynchronously, force the FSM to IDLE, clear all latched request registers and the read-data register, and reset the priority pointer to requester 0.
REQ-015 While rst_ni is low, every output SHALL be 0.
REQ-016 A reset asserted during ACCESS SHALL drop mem_write_en_o immediately, and no response SHALL be issued for the aborted transaction.

Configuration
REQ-017 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
  Defined: round-robin. After granting requester k, priority SHALL pass to requester 1-k.
  Undefined: fixed priority, requester 0 always wins a tie. The priority pointer SHALL be absent.

Verification
REQ-018 Single store then load. Requester 0: store word 0xDEADBEEF at 0x10, then load word from 0x10. Required response: mem_write_en_o high exactly one cycle, then rsp_rdata_o = 0xDEADBEEF in handshake+2.
REQ-019 Tie arbitration. Both requesters valid continuously for 4 transactions. Required response: ARB_ROUND_ROBIN_EN defined gives grant order 0,1,0,1; undefined gives 0,0,0,0.
REQ-020 Misaligned access. Halfword store at 0x13 from requester 1. Required response: mem_write_en_o stays 0, rsp_valid_o = 2'b10 and rsp_err_o = 1 in handshake+2; a later word read of 0x10 is unchanged.
REQ-021 Signed byte load. Memory word 0x000080FF, signed byte load at 0x11. Required response: mem_type_o = 00 and mem_sign_o = 1 during ACCESS, rsp_rdata_o = 0xFFFFFF80.
REQ-022 Reset mid-operation. Reset asserted during ACCESS of a store of 0x12345678 to 0x20. Required response: all outputs 0 immediately, no rsp_valid_o pulse, FSM in IDLE with requester 0 priority after release.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bundle between two load/store requesters, the data_mem_arbiter and the data-memory top.
// slave: arbiter view; master: requester/memory side view.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [1:0]                 req_valid_i;
  logic [1:0]                 req_ready_o;
  logic [1:0]                 req_we_i;
  logic [1:0][1:0]            req_type_i;
  logic [1:0]                 req_sign_i;
  logic [1:0][ADDR_WIDTH-1:0] req_addr_i;
  logic [1:0][ADDR_WIDTH-1:0] req_wdata_i;
  logic [1:0]                 rsp_valid_o;
  logic                       rsp_err_o;
  logic [ADDR_WIDTH-1:0]      rsp_rdata_o;
  logic                       mem_write_en_o;
  logic [1:0]                 mem_type_o;
  logic                       mem_sign_o;
  logic [ADDR_WIDTH-1:0]      mem_addr_o;
  logic [ADDR_WIDTH-1:0]      mem_write_data_o;
  logic [ADDR_WIDTH-1:0]      mem_read_data_i;

  modport slave (
    input  req_valid_i, req_we_i, req_type_i, req_sign_i, req_addr_i, req_wdata_i,
           mem_read_data_i,
    output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
           mem_write_en_o, mem_type_o, mem_sign_o, mem_addr_o, mem_write_data_o
  );

  modport master (
    output req_valid_i, req_we_i, req_type_i, req_sign_i, req_addr_i, req_wdata_i,
           mem_read_data_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
           mem_write_en_o, mem_type_o, mem_sign_o, mem_addr_o, mem_write_data_o
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: IDLE -> ACCESS -> RESP per request.
// `define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module data_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                state_q;
  logic                  grant_q;
  logic                  we_q;
  logic                  mis_q;
  logic                  mem_we_q;
  logic [1:0]            mem_type_q;
  logic                  mem_sign_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [ADDR_WIDTH-1:0] mem_wdata_q;
  logic [1:0]            rsp_valid_q;
  logic                  rsp_err_q;
  logic [ADDR_WIDTH-1:0] rsp_rdata_q;

  logic                  win_d;
  logic [1:0]            ready_d;
  logic [1:0]            type_d;
  logic                  mis_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_q;

  // On a tie the pointer decides; afterwards priority passes to the other requester.
  always_comb win_d = (bus.req_valid_i == 2'b11) ? prio_q : ~bus.req_valid_i[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          prio_q <= 1'b0;
    else if (|ready_d)    prio_q <= ~win_d;
  end
`else
  always_comb win_d = ~bus.req_valid_i[0];
`endif

  // Grant is combinational and forced low while reset is asserted.
  always_comb begin
    ready_d = 2'b00;
    if (rst_ni && (state_q == IDLE) && (|bus.req_valid_i)) begin
      ready_d = win_d ? 2'b10 : 2'b01;
    end
  end

  // Size 11 is folded into word before the alignment check.
  always_comb begin
    type_d = (bus.req_type_i[win_d] == 2'b11) ? 2'b10 : bus.req_type_i[win_d];
    mis_d  = ((type_d == 2'b01) && bus.req_addr_i[win_d][0]) ||
             ((type_d == 2'b10) && (bus.req_addr_i[win_d][1:0] != 2'b00));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_type_q  <= 2'b00;
      mem_sign_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|ready_d) begin
            grant_q     <= win_d;
            we_q        <= bus.req_we_i[win_d];
            mis_q       <= mis_d;
            mem_we_q    <= bus.req_we_i[win_d] & ~mis_d;
            mem_type_q  <= type_d;
            mem_sign_q  <= bus.req_sign_i[win_d];
            mem_addr_q  <= bus.req_addr_i[win_d];
            mem_wdata_q <= bus.req_wdata_i[win_d];
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
          rsp_err_q   <= mis_q;
          rsp_rdata_q <= (we_q || mis_q) ? '0 : bus.mem_read_data_i;
          mem_we_q    <= 1'b0;
          mem_type_q  <= 2'b00;
          mem_sign_q  <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 2'b00;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o      = ready_d;
  assign bus.rsp_valid_o      = rsp_valid_q;
  assign bus.rsp_err_o        = rsp_err_q;
  assign bus.rsp_rdata_o      = rsp_rdata_q;
  assign bus.mem_write_en_o   = mem_we_q;
  assign bus.mem_type_o       = mem_type_q;
  assign bus.mem_sign_o       = mem_sign_q;
  assign bus.mem_addr_o       = mem_addr_q;
  assign bus.mem_write_data_o = mem_wdata_q;

endmodule
